// File: rtl/ee354_gcd_param_core.sv
// ee354_gcd_param_core: parametrised GCD engine (subtraction Euclid or binary Stein) with step enable,
// zero-operand shortcut and saturating step counter.
module ee354_gcd_param_core #(
   parameter int WIDTH = 8,
   parameter int I_W   = 4,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             SCEN,
   input  logic             Start,
   input  logic             Ack,
   input  logic             Mode,
   input  logic [WIDTH-1:0] Ain,
   input  logic [WIDTH-1:0] Bin,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] AB_GCD,
   output logic [I_W-1:0]   i_count,
   output logic [CNT_W-1:0] Iter,
   output logic             Zero,
   output logic             q_I,
   output logic             q_Sub,
   output logic             q_Mult,
   output logic             q_Done
);
   typedef enum logic [1:0] {S_INIT, S_SUB, S_MULT, S_DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
   logic [I_W-1:0]   icnt_q, icnt_d;
   logic [CNT_W-1:0] iter_q, iter_d;
   logic             zero_q, zero_d, mode_q, mode_d;
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      gcd_d   = gcd_q;
      icnt_d  = icnt_q;
      iter_d  = iter_q;
      zero_d  = zero_q;
      mode_d  = mode_q;
      case (state_q)
         S_INIT: if (Start) begin
            a_d     = Ain;
            b_d     = Bin;
            mode_d  = Mode;
            icnt_d  = '0;
            iter_d  = '0;
            zero_d  = (Ain == '0) || (Bin == '0);
            gcd_d   = zero_d ? (Ain | Bin) : '0;
            state_d = zero_d ? S_DONE : S_SUB;
         end
         S_SUB: if (SCEN) begin
            iter_d = &iter_q ? iter_q : iter_q + 1'b1;
            if (a_q == b_q) begin
               gcd_d   = a_q;
               state_d = (icnt_q != '0) ? S_MULT : S_DONE;
            end else if (mode_q && !a_q[0] && !b_q[0]) begin
               a_d    = a_q >> 1;
               b_d    = b_q >> 1;
               icnt_d = icnt_q + 1'b1;
            end else if (mode_q && !a_q[0]) begin
               a_d = a_q >> 1;
            end else if (mode_q && !b_q[0]) begin
               b_d = b_q >> 1;
            end else if (a_q > b_q) begin
               a_d = a_q - b_q;
            end else begin
               b_d = b_q - a_q;
            end
         end
         S_MULT: if (SCEN) begin
            gcd_d   = gcd_q << 1;
            icnt_d  = icnt_q - 1'b1;
            state_d = (icnt_q == I_W'(1)) ? S_DONE : S_MULT;
         end
         default: state_d = Ack ? S_INIT : S_DONE;
      endcase
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_INIT;
         a_q     <= '0;
         b_q     <= '0;
         gcd_q   <= '0;
         icnt_q  <= '0;
         iter_q  <= '0;
         zero_q  <= 1'b0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gcd_q   <= gcd_d;
         icnt_q  <= icnt_d;
         iter_q  <= iter_d;
         zero_q  <= zero_d;
         mode_q  <= mode_d;
      end
   end
   assign A       = a_q;
   assign B       = b_q;
   assign AB_GCD  = gcd_q;
   assign i_count = icnt_q;
   assign Iter    = iter_q;
   assign Zero    = zero_q;
   assign q_I     = state_q == S_INIT;
   assign q_Sub   = state_q == S_SUB;
   assign q_Mult  = state_q == S_MULT;
   assign q_Done  = state_q == S_DONE;
endmodule
